// File: rtl/usb_dev_rw_responder.sv
// Device-side responder for the two-transaction host read/write sequence:
// an address packet on ADDR_ENDP, then a 64-bit write or read on DATA_ENDP.
module usb_dev_rw_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        tok_valid,
    input  logic        tok_in,
    input  logic [6:0]  tok_addr,
    input  logic [3:0]  tok_endp,
    input  logic        rx_valid,
    input  logic        rx_crc_ok,
    input  logic [63:0] rx_data,
    output logic        hs_send,
    output logic        hs_ack,
    output logic        tx_valid,
    output logic [63:0] tx_data,
    input  logic        tx_ready,
    input  logic        host_hs_valid,
    input  logic        host_hs_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic [2:0]  state_dbg
);

    // Handshakes: tok_valid/rx_valid/host_hs_valid/hs_send are single-cycle pulses;
    // mem_req holds until mem_gnt, tx_valid holds until tx_ready (transfer on valid & ready).
    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_HAVE_ADDR, S_GET_WDATA,
        S_MEM_WR, S_MEM_RD, S_SEND_DATA, S_WAIT_HS
    } state_t;

    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

    state_t     state, next_state;
    logic [7:0] tmo_cnt;
    logic       wr_done_q;
    logic       hs_set, hs_ack_set, done_set, err_set, wr_done_set;
    logic       tok_hit, tok_out_addr, tok_out_data, tok_in_data;
    logic       any_event, timed, tmo_hit;
    logic       addr_load, wdata_load, rdata_load;

    // A token arriving together with rx_valid is dropped.
    assign tok_hit      = tok_valid && !rx_valid && (tok_addr == DEV_ADDR);
    assign tok_out_addr = tok_hit && !tok_in && (tok_endp == ADDR_ENDP);
    assign tok_out_data = tok_hit && !tok_in && (tok_endp == DATA_ENDP);
    assign tok_in_data  = tok_hit &&  tok_in && (tok_endp == DATA_ENDP);
    assign any_event    = tok_valid || rx_valid || host_hs_valid;
    assign timed        = (state == S_GET_ADDR) || (state == S_HAVE_ADDR) ||
                          (state == S_GET_WDATA) || (state == S_SEND_DATA) ||
                          (state == S_WAIT_HS);
    assign tmo_hit      = timed && !any_event && (tmo_cnt == TMO_MAX);
    assign addr_load    = (state == S_GET_ADDR) && rx_valid && rx_crc_ok;
    assign wdata_load   = (state == S_GET_WDATA) && rx_valid && rx_crc_ok;
    assign rdata_load   = (state == S_MEM_RD) && mem_gnt;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        hs_set      = 1'b0;
        hs_ack_set  = 1'b0;
        done_set    = 1'b0;
        err_set     = 1'b0;
        wr_done_set = 1'b0;
        case (state)
            S_IDLE: if (tok_out_addr) next_state = S_GET_ADDR;
            S_GET_ADDR: begin
                if (rx_valid) begin
                    hs_set     = 1'b1;
                    hs_ack_set = rx_crc_ok;
                    if (rx_crc_ok) next_state = S_HAVE_ADDR;
                end
            end
            S_HAVE_ADDR: begin
                if (tok_out_data)      next_state = S_GET_WDATA;
                else if (tok_in_data)  next_state = S_MEM_RD;
                else if (tok_out_addr) next_state = S_GET_ADDR;
                else if (tok_hit) begin
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_GET_WDATA: begin
                if (rx_valid && rx_crc_ok) next_state = S_MEM_WR;
                else if (rx_valid)         hs_set = 1'b1;
            end
            // The write ACK waits for the memory commit; done follows one cycle later.
            S_MEM_WR: begin
                if (mem_gnt) begin
                    hs_set      = 1'b1;
                    hs_ack_set  = 1'b1;
                    wr_done_set = 1'b1;
                    next_state  = S_IDLE;
                end
            end
            S_MEM_RD:    if (mem_gnt) next_state = S_SEND_DATA;
            S_SEND_DATA: if (tx_ready) next_state = S_WAIT_HS;
            S_WAIT_HS: begin
                if (host_hs_valid && host_hs_ack) begin
                    done_set   = 1'b1;
                    next_state = S_IDLE;
                end else if (host_hs_valid || tok_in_data) begin
                    next_state = S_SEND_DATA;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (tmo_hit) begin
            err_set    = 1'b1;
            next_state = S_IDLE;
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        mem_req   = (state == S_MEM_WR) || (state == S_MEM_RD);
        mem_we    = (state == S_MEM_WR);
        tx_valid  = (state == S_SEND_DATA);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            hs_send   <= 1'b0;
            hs_ack    <= 1'b0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            wr_done_q <= 1'b0;
            tmo_cnt   <= 8'd0;
            mem_addr  <= 16'd0;
            mem_wdata <= 64'd0;
            tx_data   <= 64'd0;
        end else begin
            hs_send   <= hs_set;
            hs_ack    <= hs_ack_set;
            xfer_err  <= err_set;
            wr_done_q <= wr_done_set;
            xfer_done <= done_set || wr_done_q;
            if ((next_state != state) || any_event) tmo_cnt <= 8'd0;
            else if (timed)                         tmo_cnt <= tmo_cnt + 8'd1;
            if (addr_load)  mem_addr  <= rx_data[15:0];
            if (wdata_load) mem_wdata <= rx_data;
            if (rdata_load) tx_data   <= mem_rdata;
        end
    end

endmodule
